// File: rtl/video_led_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the segment-LED pattern sequencer.
package video_led_seq_pkg;

    localparam int unsigned C_LED_N     = 18;
    localparam int unsigned C_SLOT_N    = 8;
    localparam logic [7:0]  C_TICK_LINE = 8'd240;
    localparam int unsigned C_BLINK_FR  = 16;

    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned C_SLOT_NW = log2_ceil(C_SLOT_N);

    typedef enum logic {
        StIdle = 1'b0,
        StPlay = 1'b1
    } state_e;

    // Out-of-range final-slot requests play up to the last physical slot.
    function automatic logic [C_SLOT_NW-1:0] clamp_slot(input logic [C_SLOT_NW-1:0] s);
        int unsigned v;
        v = int'(s);
        if (v >= C_SLOT_N) begin
            return C_SLOT_NW'(C_SLOT_N - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/video_led_frame_tick.sv
// Once-per-frame tick from the raster counters, plus the blink-phase frame counter.
module video_led_frame_tick
    import video_led_seq_pkg::*;
(
    input  logic       CK_i,
    input  logic       ARST_i,
    input  logic       CK_EE_i,
    input  logic [8:0] HCTRs_i,
    input  logic [7:0] VCTRs_i,
    output logic       TICK_o,
    output logic       PHASE_o
);

    logic        match;
    logic        match_q;
    logic [15:0] fr_cnt_q;
    logic        phase_q;

    assign match   = (VCTRs_i == C_TICK_LINE) && (HCTRs_i == 9'd0);
    // Rising edge only, so a match held over several cycles still yields one tick.
    assign TICK_o  = CK_EE_i & match & ~match_q;
    assign PHASE_o = phase_q;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            match_q  <= 1'b0;
            fr_cnt_q <= '0;
            phase_q  <= 1'b0;
        end else if (CK_EE_i) begin
            match_q <= match;
            if (TICK_o) begin
                if (fr_cnt_q == 16'(C_BLINK_FR - 1)) begin
                    fr_cnt_q <= '0;
                    phase_q  <= ~phase_q;
                end else begin
                    fr_cnt_q <= fr_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/video_led_seq.sv
// Frame-synchronous LED pattern sequencer: slot memory, dwell/loop playback, blink mask.
module video_led_seq
    import video_led_seq_pkg::*;
(
    input  logic                 CK_i,
    input  logic                 ARST_i,
    input  logic                 CK_EE_i,
    input  logic [8:0]           HCTRs_i,
    input  logic [7:0]           VCTRs_i,
    input  logic                 START_i,
    input  logic                 STOP_i,
    input  logic                 LOOP_i,
    input  logic [C_SLOT_NW-1:0] LAST_SLOTs_i,
    input  logic [7:0]           DWELLs_i,
    input  logic [C_LED_N-1:0]   BLINK_MSKs_i,
    input  logic                 WR_REQ_i,
    input  logic [C_SLOT_NW-1:0] WR_ADDRs_i,
    input  logic [C_LED_N-1:0]   WR_DATAs_i,
    output logic                 WR_ACK_o,
    output logic [C_LED_N-1:0]   LEDs_ON_o,
    output logic [C_SLOT_NW-1:0] SLOTs_o,
    output logic                 BUSY_o,
    output logic                 DONE_o
);

    logic tick;
    logic phase;

    state_e               state_q, state_d;
    logic [C_SLOT_NW-1:0] slot_q, slot_d;
    logic [7:0]           dwell_q, dwell_d;
    logic                 load_q, load_d;
    logic                 clr_q, clr_d;
    logic [C_LED_N-1:0]   shadow_q, shadow_d;
    logic [C_LED_N-1:0]   leds_q, leds_d;
    logic                 done_q, done_d;
    logic                 ack_q;
    logic [C_LED_N-1:0]   mem_q [C_SLOT_N];

    logic [C_SLOT_NW-1:0] last_eff;
    logic [C_SLOT_NW-1:0] slot_nx;
    logic [7:0]           dwell_max;

    video_led_frame_tick u_frame_tick (
        .CK_i    (CK_i),
        .ARST_i  (ARST_i),
        .CK_EE_i (CK_EE_i),
        .HCTRs_i (HCTRs_i),
        .VCTRs_i (VCTRs_i),
        .TICK_o  (tick),
        .PHASE_o (phase)
    );

    assign last_eff  = clamp_slot(LAST_SLOTs_i);
    assign slot_nx   = slot_q + 1'b1;
    assign dwell_max = (DWELLs_i == 8'd0) ? 8'd0 : DWELLs_i - 8'd1;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        dwell_d  = dwell_q;
        load_d   = load_q;
        clr_d    = clr_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;

        if (tick) begin
            if (state_q == StPlay) begin
                if (load_q) begin
                    // First tick after START only shows slot 0; dwell counting begins next tick.
                    shadow_d = mem_q[slot_q];
                    load_d   = 1'b0;
                end else if (dwell_q >= dwell_max) begin
                    dwell_d = 8'd0;
                    if (slot_q >= last_eff) begin
                        if (LOOP_i) begin
                            slot_d   = '0;
                            shadow_d = mem_q[0];
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        slot_d   = slot_nx;
                        shadow_d = mem_q[slot_nx];
                    end
                end else begin
                    dwell_d  = dwell_q + 8'd1;
                    shadow_d = mem_q[slot_q];
                end
            end else if (clr_q) begin
                shadow_d = '0;
                clr_d    = 1'b0;
            end
        end

        if (START_i) begin
            state_d = StPlay;
            slot_d  = '0;
            dwell_d = 8'd0;
            load_d  = 1'b1;
            clr_d   = 1'b0;
            done_d  = 1'b0;
        end
        if (STOP_i) begin
            state_d = StIdle;
            load_d  = 1'b0;
            clr_d   = 1'b1;
            done_d  = 1'b0;
        end

        leds_d = shadow_d & ~(BLINK_MSKs_i & {C_LED_N{phase}});
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            dwell_q  <= 8'd0;
            load_q   <= 1'b0;
            clr_q    <= 1'b0;
            shadow_q <= '0;
            leds_q   <= '0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            for (int unsigned i = 0; i < C_SLOT_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (CK_EE_i) begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            dwell_q  <= dwell_d;
            load_q   <= load_d;
            clr_q    <= clr_d;
            shadow_q <= shadow_d;
            leds_q   <= leds_d;
            done_q   <= done_d;
            // A held request re-acks only after a gap, keeping ACK a single-cycle pulse.
            ack_q    <= WR_REQ_i & ~ack_q;
            if (WR_REQ_i) begin
                mem_q[WR_ADDRs_i] <= WR_DATAs_i;
            end
        end
    end

    assign WR_ACK_o  = ack_q & CK_EE_i;
    assign LEDs_ON_o = leds_q;
    assign SLOTs_o   = slot_q;
    assign BUSY_o    = (state_q == StPlay);
    assign DONE_o    = done_q;

endmodule

// File: tb/tb_video_led_seq.sv
// Directed self-checking bench for video_led_seq; raster counters are driven directly.
module tb_video_led_seq;
    import video_led_seq_pkg::*;

    logic                 CK_i = 1'b0;
    logic                 ARST_i;
    logic                 CK_EE_i;
    logic [8:0]           HCTRs_i;
    logic [7:0]           VCTRs_i;
    logic                 START_i;
    logic                 STOP_i;
    logic                 LOOP_i;
    logic [C_SLOT_NW-1:0] LAST_SLOTs_i;
    logic [7:0]           DWELLs_i;
    logic [C_LED_N-1:0]   BLINK_MSKs_i;
    logic                 WR_REQ_i;
    logic [C_SLOT_NW-1:0] WR_ADDRs_i;
    logic [C_LED_N-1:0]   WR_DATAs_i;
    logic                 WR_ACK_o;
    logic [C_LED_N-1:0]   LEDs_ON_o;
    logic [C_SLOT_NW-1:0] SLOTs_o;
    logic                 BUSY_o;
    logic                 DONE_o;

    int checks = 0;
    int failures = 0;

    video_led_seq dut (
        .CK_i         (CK_i),
        .ARST_i       (ARST_i),
        .CK_EE_i      (CK_EE_i),
        .HCTRs_i      (HCTRs_i),
        .VCTRs_i      (VCTRs_i),
        .START_i      (START_i),
        .STOP_i       (STOP_i),
        .LOOP_i       (LOOP_i),
        .LAST_SLOTs_i (LAST_SLOTs_i),
        .DWELLs_i     (DWELLs_i),
        .BLINK_MSKs_i (BLINK_MSKs_i),
        .WR_REQ_i     (WR_REQ_i),
        .WR_ADDRs_i   (WR_ADDRs_i),
        .WR_DATAs_i   (WR_DATAs_i),
        .WR_ACK_o     (WR_ACK_o),
        .LEDs_ON_o    (LEDs_ON_o),
        .SLOTs_o      (SLOTs_o),
        .BUSY_o       (BUSY_o),
        .DONE_o       (DONE_o)
    );

    always #5 CK_i = ~CK_i;

    task automatic do_reset();
        ARST_i       = 1'b1;
        CK_EE_i      = 1'b1;
        HCTRs_i      = 9'd1;
        VCTRs_i      = 8'd0;
        START_i      = 1'b0;
        STOP_i       = 1'b0;
        LOOP_i       = 1'b0;
        LAST_SLOTs_i = '0;
        DWELLs_i     = 8'd0;
        BLINK_MSKs_i = '0;
        WR_REQ_i     = 1'b0;
        WR_ADDRs_i   = '0;
        WR_DATAs_i   = '0;
        repeat (2) @(negedge CK_i);
        ARST_i = 1'b0;
        @(negedge CK_i);
    endtask

    // Returns at the falling edge just after the tick edge.
    task automatic frame();
        @(negedge CK_i);
        VCTRs_i = C_TICK_LINE;
        HCTRs_i = 9'd0;
        @(negedge CK_i);
        VCTRs_i = 8'd0;
        HCTRs_i = 9'd1;
    endtask

    task automatic wr(input logic [C_SLOT_NW-1:0] a, input logic [C_LED_N-1:0] d);
        @(negedge CK_i);
        WR_REQ_i   = 1'b1;
        WR_ADDRs_i = a;
        WR_DATAs_i = d;
        @(negedge CK_i);
        WR_REQ_i = 1'b0;
        @(negedge CK_i);
    endtask

    task automatic pulse_start();
        @(negedge CK_i);
        START_i = 1'b1;
        @(negedge CK_i);
        START_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (LEDs_ON_o !== '0) begin
            failures++;
            $display("FAIL reset_leds got=%h exp=0", LEDs_ON_o);
        end
        checks++;
        if ({SLOTs_o, BUSY_o, DONE_o, WR_ACK_o} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got slot=%0d busy=%b done=%b ack=%b exp all 0",
                     SLOTs_o, BUSY_o, DONE_o, WR_ACK_o);
        end
    endtask

    task automatic test_play_once();
        logic [C_LED_N-1:0] exp_led [4];
        logic [C_SLOT_NW-1:0] exp_slot [4];
        exp_led  = '{18'h3FFFF, 18'h3FFFF, 18'h00001, 18'h00001};
        exp_slot = '{3'd0, 3'd0, 3'd1, 3'd1};
        do_reset();
        wr(3'd0, 18'h3FFFF);
        wr(3'd1, 18'h00001);
        LAST_SLOTs_i = 3'd1;
        DWELLs_i     = 8'd2;
        LOOP_i       = 1'b0;
        pulse_start();
        checks++;
        if (BUSY_o !== 1'b1) begin
            failures++;
            $display("FAIL once_busy_after_start got=%b exp=1", BUSY_o);
        end
        for (int k = 0; k < 4; k++) begin
            frame();
            checks++;
            if (LEDs_ON_o !== exp_led[k] || SLOTs_o !== exp_slot[k] || DONE_o !== 1'b0) begin
                failures++;
                $display("FAIL once_tick%0d got led=%h slot=%0d done=%b exp led=%h slot=%0d done=0",
                         k + 1, LEDs_ON_o, SLOTs_o, DONE_o, exp_led[k], exp_slot[k]);
            end
        end
        frame();
        checks++;
        if (DONE_o !== 1'b1 || BUSY_o !== 1'b0) begin
            failures++;
            $display("FAIL once_done got done=%b busy=%b exp done=1 busy=0", DONE_o, BUSY_o);
        end
        @(negedge CK_i);
        checks++;
        if (DONE_o !== 1'b0 || LEDs_ON_o !== 18'h00001) begin
            failures++;
            $display("FAIL once_hold got done=%b led=%h exp done=0 led=00001", DONE_o, LEDs_ON_o);
        end
        frame();
        checks++;
        if (LEDs_ON_o !== 18'h00001 || BUSY_o !== 1'b0) begin
            failures++;
            $display("FAIL once_hold_tick got led=%h busy=%b exp led=00001 busy=0",
                     LEDs_ON_o, BUSY_o);
        end
    endtask

    task automatic test_loop();
        logic [C_LED_N-1:0] pat [3];
        logic [C_SLOT_NW-1:0] exp_slot [6];
        pat      = '{18'h00011, 18'h00022, 18'h00033};
        exp_slot = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        do_reset();
        for (int i = 0; i < 3; i++) wr(3'(i), pat[i]);
        LOOP_i       = 1'b1;
        LAST_SLOTs_i = 3'd2;
        DWELLs_i     = 8'd0;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            frame();
            checks++;
            if (SLOTs_o !== exp_slot[k] || LEDs_ON_o !== pat[exp_slot[k]] || BUSY_o !== 1'b1) begin
                failures++;
                $display("FAIL loop_tick%0d got slot=%0d led=%h busy=%b exp slot=%0d led=%h busy=1",
                         k + 1, SLOTs_o, LEDs_ON_o, BUSY_o, exp_slot[k], pat[exp_slot[k]]);
            end
        end
    endtask

    task automatic test_blink();
        logic [C_LED_N-1:0] exp;
        do_reset();
        wr(3'd0, 18'h3FFFF);
        BLINK_MSKs_i = 18'h00003;
        LOOP_i       = 1'b1;
        LAST_SLOTs_i = 3'd0;
        pulse_start();
        for (int k = 1; k <= 33; k++) begin
            frame();
            @(negedge CK_i);
            exp = (k >= 16 && k < 32) ? 18'h3FFFC : 18'h3FFFF;
            checks++;
            if (LEDs_ON_o !== exp) begin
                failures++;
                $display("FAIL blink_frame%0d got=%h exp=%h", k, LEDs_ON_o, exp);
            end
        end
    endtask

    task automatic test_write_displayed();
        do_reset();
        wr(3'd0, 18'h00AAA);
        LOOP_i = 1'b1;
        pulse_start();
        frame();
        checks++;
        if (LEDs_ON_o !== 18'h00AAA) begin
            failures++;
            $display("FAIL wr_initial got=%h exp=00AAA", LEDs_ON_o);
        end
        @(negedge CK_i);
        WR_REQ_i   = 1'b1;
        WR_ADDRs_i = 3'd0;
        WR_DATAs_i = 18'h00555;
        @(negedge CK_i);
        checks++;
        if (WR_ACK_o !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack_pulse got=%b exp=1", WR_ACK_o);
        end
        @(negedge CK_i);
        WR_REQ_i = 1'b0;
        checks++;
        if (WR_ACK_o !== 1'b0 || LEDs_ON_o !== 18'h00AAA) begin
            failures++;
            $display("FAIL wr_ack_end got ack=%b led=%h exp ack=0 led=00AAA", WR_ACK_o, LEDs_ON_o);
        end
        frame();
        checks++;
        if (LEDs_ON_o !== 18'h00555) begin
            failures++;
            $display("FAIL wr_visible got=%h exp=00555", LEDs_ON_o);
        end
        // Write coinciding with the tick edge: shadow must take the old contents.
        @(negedge CK_i);
        VCTRs_i    = C_TICK_LINE;
        HCTRs_i    = 9'd0;
        WR_REQ_i   = 1'b1;
        WR_DATAs_i = 18'h00F0F;
        @(negedge CK_i);
        VCTRs_i  = 8'd0;
        HCTRs_i  = 9'd1;
        WR_REQ_i = 1'b0;
        checks++;
        if (LEDs_ON_o !== 18'h00555) begin
            failures++;
            $display("FAIL wr_same_tick got=%h exp=00555", LEDs_ON_o);
        end
        frame();
        checks++;
        if (LEDs_ON_o !== 18'h00F0F) begin
            failures++;
            $display("FAIL wr_same_tick_next got=%h exp=00F0F", LEDs_ON_o);
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        wr(3'd0, 18'h0000F);
        LOOP_i = 1'b1;
        @(negedge CK_i);
        START_i = 1'b1;
        STOP_i  = 1'b1;
        @(negedge CK_i);
        START_i = 1'b0;
        STOP_i  = 1'b0;
        checks++;
        if (BUSY_o !== 1'b0) begin
            failures++;
            $display("FAIL startstop_busy got=%b exp=0", BUSY_o);
        end
        frame();
        checks++;
        if (LEDs_ON_o !== '0 || BUSY_o !== 1'b0) begin
            failures++;
            $display("FAIL startstop_idle got led=%h busy=%b exp led=0 busy=0", LEDs_ON_o, BUSY_o);
        end
        pulse_start();
        frame();
        checks++;
        if (LEDs_ON_o !== 18'h0000F) begin
            failures++;
            $display("FAIL stop_pre got=%h exp=0000F", LEDs_ON_o);
        end
        @(negedge CK_i);
        STOP_i = 1'b1;
        @(negedge CK_i);
        STOP_i = 1'b0;
        checks++;
        if (BUSY_o !== 1'b0 || LEDs_ON_o !== 18'h0000F || DONE_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_before_tick got busy=%b led=%h done=%b exp busy=0 led=0000F done=0",
                     BUSY_o, LEDs_ON_o, DONE_o);
        end
        frame();
        checks++;
        if (LEDs_ON_o !== '0) begin
            failures++;
            $display("FAIL stop_cleared got=%h exp=0", LEDs_ON_o);
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        wr(3'd0, 18'h2AAAA);
        LOOP_i = 1'b1;
        pulse_start();
        frame();
        #2;
        ARST_i = 1'b1;
        #1;
        checks++;
        if ({LEDs_ON_o, SLOTs_o, BUSY_o, DONE_o, WR_ACK_o} !== '0) begin
            failures++;
            $display("FAIL arst_async got led=%h slot=%0d busy=%b done=%b ack=%b exp all 0",
                     LEDs_ON_o, SLOTs_o, BUSY_o, DONE_o, WR_ACK_o);
        end
        @(negedge CK_i);
        ARST_i = 1'b0;
    endtask

    task automatic test_clock_enable();
        do_reset();
        wr(3'd0, 18'h12345);
        wr(3'd1, 18'h00042);
        LOOP_i       = 1'b1;
        LAST_SLOTs_i = 3'd1;
        pulse_start();
        frame();
        @(negedge CK_i);
        CK_EE_i    = 1'b0;
        VCTRs_i    = C_TICK_LINE;
        HCTRs_i    = 9'd0;
        WR_REQ_i   = 1'b1;
        WR_ADDRs_i = 3'd1;
        WR_DATAs_i = 18'h3FFFF;
        repeat (3) @(negedge CK_i);
        checks++;
        if (WR_ACK_o !== 1'b0) begin
            failures++;
            $display("FAIL ce_ack_low got=%b exp=0", WR_ACK_o);
        end
        VCTRs_i  = 8'd0;
        HCTRs_i  = 9'd1;
        WR_REQ_i = 1'b0;
        @(negedge CK_i);
        CK_EE_i = 1'b1;
        repeat (2) @(negedge CK_i);
        checks++;
        if (SLOTs_o !== 3'd0 || LEDs_ON_o !== 18'h12345) begin
            failures++;
            $display("FAIL ce_hold got slot=%0d led=%h exp slot=0 led=12345", SLOTs_o, LEDs_ON_o);
        end
        frame();
        checks++;
        if (SLOTs_o !== 3'd1 || LEDs_ON_o !== 18'h00042) begin
            failures++;
            $display("FAIL ce_resume got slot=%0d led=%h exp slot=1 led=00042", SLOTs_o, LEDs_ON_o);
        end
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop();
        test_blink();
        test_write_displayed();
        test_start_stop();
        test_reset_mid_play();
        test_clock_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
